alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute stage ALU. Consumes the 4-bit ALU op produced by the ALU control decoder and applies it to two
//  32-bit operands. Most ops finish in 1 cycle. Shifts are iterative, 1 bit/cycle, unless fast-shift is compiled in.
//  Valid/ready handshake on both sides; sits between the register-read stage and writeback/branch logic.
// PARAMETERS
//  XLEN   32  operand/result width (spec and tests fixed at 32)
//  SHAMTW 5   shift-amount width; shamt = iB[SHAMTW-1:0]
// PORTS
//  iClk     in   1     clock, rising edge
//  iRst_n   in   1     async active-low reset
//  iValid   in   1     operation request valid
//  oReady   out  1     unit can accept; transfer when iValid && oReady
//  iALUOP   in   4     ALU op code (alu_pkg encodings)
//  iA       in   XLEN  operand A (rs1)
//  iB       in   XLEN  operand B (rs2 or immediate)
//  oValid   out  1     result valid; held until iReady
//  iReady   in   1     downstream accepts; transfer when oValid && iReady
//  oResult  out  XLEN  registered result
//  oZero    out  1     (oResult == 0), for branch compare
//  oBusy    out  1     state != IDLE
// BEHAVIOUR
//  - Reset (async, iRst_n=0): state=IDLE, oValid=0, oResult=0, oZero=1, shift counter=0.
//  - FSM IDLE/SHIFT/DONE. oReady = IDLE || (DONE && iReady).
//  - Accept (edge 0): latch op/iA/iB. Non-shift op, or shamt==0, goes to DONE with oValid=1 at cycle 1.
//  - Shift op with shamt>0 goes to SHIFT with cnt=shamt. Each SHIFT cycle shifts 1 bit and does cnt--.
//    When cnt==1 it goes to DONE; oValid is high from cycle shamt+1.
//  - DONE && iReady: if a new accept happens the same cycle, follow the accept rules; else go to IDLE, oValid=0.
//  - DONE && !iReady: oResult and oValid held stable; no accept.
//  - Ops: ADD/SUB wrap mod 2^32. XOR/OR/AND bitwise. SLL/SRL shift in zeros; SRA shifts in A[31].
//    SLT is a signed compare; SLTU is unsigned. Both give a 32-bit result, 0 or 1.
//  - Op codes 4'hA..4'hF execute as ADD; no error is flagged.
//  - iALUOP/iA/iB are sampled only on accept; later changes are ignored.
//  - Reset mid-operation abandons the op: no oValid pulse, state goes to IDLE.
// CONFIGURATION
//  ALU_FAST_SHIFT_EN defined: shifts use a 1-cycle barrel shifter, so every op has latency 1; SHIFT state unreachable.
//  Undefined: iterative shifter as above, latency shamt+1 (max 32).
// STRUCTURE
//  alu_pkg: ALU_ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9 (4-bit).
//  alu_pkg also holds the state enum IDLE/SHIFT/DONE and the is_shift(op) function. The decoder imports the same package.
//  Sub-module alu_shifter: 1-bit/cycle shift register + down-counter (or barrel under ALU_FAST_SHIFT_EN).
//  Handshake, FSM and the combinational ops stay in alu_exec_unit.
// TESTING
//  1. ADD A=32'hFFFFFFFF, B=1 -> oResult=0, oZero=1, oValid at cycle 1, iReady=1 -> IDLE at cycle 2.
//  2. SUB 5-7 -> 32'hFFFFFFFE. SLT(-1,1) -> 1. SLTU(32'hFFFFFFFF,1) -> 0. XOR A5A5A5A5^FFFFFFFF -> 5A5A5A5A.
//  3. SRA A=32'h80000000, B=4 -> 32'hF8000000, oValid first at cycle 5, oReady=0 cycles 1-4.
//     With ALU_FAST_SHIFT_EN the same op has oValid at cycle 1.
//  4. Backpressure: iReady=0 for 3 cycles in DONE -> oResult/oValid stable, oReady=0.
//     Then iReady=1 with iValid=1 (AND F0F0,0FF0) -> consumed and accepted same edge, next result 32'h000000F0 at +1.
//  5. SLL B=31 accepted, iRst_n=0 at cycle 10 -> oValid=0, oBusy=0, oResult=0. After release, ADD 2+3 -> 5 at latency 1.
//  6. iALUOP=4'hC, A=2, B=3 -> 5. SLL A=1, B=32'h21 -> shamt=1, result 2 at cycle 2. SLL B=0 -> result A at cycle 1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU op encodings, FSM states and helpers shared
// by the ALU control decoder and the execute-stage ALU.
package alu_pkg;

  localparam int XLEN   = 32;
  localparam int SHAMTW = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_XOR  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_AND  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(
    input logic [3:0] op
  );
    return (op == ALU_SLL) ||
           (op == ALU_SRL) ||
           (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: 1-bit/cycle shift register with down-counter,
// or a single-cycle barrel shifter when ALU_FAST_SHIFT_EN is set.
module alu_shifter
  import alu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [3:0]        i_op,
  input  logic [XLEN-1:0]   i_a,
  input  logic [SHAMTW-1:0] i_shamt,
  output logic [XLEN-1:0]   o_result,
  output logic              o_last
);

`ifdef ALU_FAST_SHIFT_EN

  logic w_unused;
  assign w_unused = ^{i_clk, i_rst_n, i_load};

  always_comb begin
    case (i_op)
      ALU_SLL: o_result = i_a << i_shamt;
      ALU_SRA: o_result = XLEN'($signed(i_a) >>> i_shamt);
      default: o_result = i_a >> i_shamt;
    endcase
  end

  assign o_last = 1'b0;

`else

  logic [XLEN-1:0]   r_data;
  logic [SHAMTW-1:0] r_cnt;
  logic [3:0]        r_op;
  logic [XLEN-1:0]   w_next;

  always_comb begin
    case (r_op)
      ALU_SLL: w_next = {r_data[XLEN-2:0], 1'b0};
      ALU_SRA: w_next = {r_data[XLEN-1], r_data[XLEN-1:1]};
      default: w_next = {1'b0, r_data[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_op   <= '0;
    end else if (i_load) begin
      r_data <= i_a;
      r_cnt  <= i_shamt;
      r_op   <= i_op;
    end else if (r_cnt != '0) begin
      r_data <= w_next;
      r_cnt  <= r_cnt - 1'b1;
    end
  end

  // The final step's value is presented combinationally so the
  // FSM can capture it on the same edge it leaves SHIFT.
  assign o_result = w_next;
  assign o_last   = (r_cnt == SHAMTW'(1));

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshake.
// Shifts iterate 1 bit/cycle unless ALU_FAST_SHIFT_EN is defined.
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic            iClk,
  input  logic            iRst_n,
  input  logic            iValid,
  output logic            oReady,
  input  logic [3:0]      iALUOP,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  output logic            oValid,
  input  logic            iReady,
  output logic [XLEN-1:0] oResult,
  output logic            oZero,
  output logic            oBusy
);

  state_e            r_state;
  state_e            w_next;
  state_e            w_acc_state;
  logic [XLEN-1:0]   r_result;
  logic [XLEN-1:0]   w_exec;
  logic [XLEN-1:0]   w_sh_result;
  logic [SHAMTW-1:0] w_shamt;
  logic              w_accept;
  logic              w_sh_load;
  logic              w_sh_last;

  assign w_shamt   = iB[SHAMTW-1:0];
  assign w_accept  = iValid && oReady;
  assign w_sh_load = w_accept && is_shift(iALUOP);

  alu_shifter u_shifter (
    .i_clk    (iClk),
    .i_rst_n  (iRst_n),
    .i_load   (w_sh_load),
    .i_op     (iALUOP),
    .i_a      (iA),
    .i_shamt  (w_shamt),
    .o_result (w_sh_result),
    .o_last   (w_sh_last)
  );

  always_comb begin
    w_exec = iA + iB;
    case (iALUOP)
      ALU_SUB: w_exec = iA - iB;
      ALU_XOR: w_exec = iA ^ iB;
      ALU_OR:  w_exec = iA | iB;
      ALU_AND: w_exec = iA & iB;
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL, ALU_SRL, ALU_SRA:
        w_exec = w_sh_result;
`else
      ALU_SLL, ALU_SRL, ALU_SRA:
        w_exec = iA;
`endif
      ALU_SLT:
        w_exec = {{(XLEN-1){1'b0}},
                  $signed(iA) < $signed(iB)};
      ALU_SLTU:
        w_exec = {{(XLEN-1){1'b0}}, iA < iB};
      default: w_exec = iA + iB;
    endcase
  end

`ifdef ALU_FAST_SHIFT_EN
  assign w_acc_state = S_DONE;
`else
  // A zero shift amount is a plain copy of A: no SHIFT visit.
  assign w_acc_state =
    (is_shift(iALUOP) && (w_shamt != '0)) ?
    S_SHIFT : S_DONE;
`endif

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (w_accept) w_next = w_acc_state;
      S_SHIFT:
        if (w_sh_last) w_next = S_DONE;
      S_DONE:
        if (iReady)
          w_next = w_accept ? w_acc_state : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    oValid = (r_state == S_DONE);
    oBusy  = (r_state != S_IDLE);
    oReady = (r_state == S_IDLE) ||
             ((r_state == S_DONE) && iReady);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_result <= '0;
    end else if (w_accept && (w_acc_state == S_DONE)) begin
      r_result <= w_exec;
    end else if ((r_state == S_SHIFT) && w_sh_last) begin
      r_result <= w_sh_result;
    end
  end

  assign oResult = r_result;
  assign oZero   = (r_result == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: vector table, random ops against a
// behavioural model, plus backpressure and reset sequences.
module tb_alu_exec_unit;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic        iValid;
  logic        oReady;
  logic [3:0]  iALUOP;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        oValid;
  logic        iReady;
  logic [31:0] oResult;
  logic        oZero;
  logic        oBusy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t tbl[18];

  alu_exec_unit dut (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iValid  (iValid),
    .oReady  (oReady),
    .iALUOP  (iALUOP),
    .iA      (iA),
    .iB      (iB),
    .oValid  (oValid),
    .iReady  (iReady),
    .oResult (oResult),
    .oZero   (oZero),
    .oBusy   (oBusy)
  );

  always #5 iClk = ~iClk;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    int unsigned sh;
    longint sa;
    longint sb;
    sh = b % 32;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: return a - b;
      4'd2: return a ^ b;
      4'd3: return a | b;
      4'd4: return a & b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return 32'(sa >>> sh);
      4'd8: return (sa < sb) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  function automatic int model_lat(
    input logic [3:0]  op,
    input logic [31:0] b
  );
    int unsigned sh;
    sh = b % 32;
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    if (op >= 4'd5 && op <= 4'd7 && sh != 0)
      return int'(sh) + 1;
    return 1;
`endif
  endfunction

  // Called on a falling edge with the unit idle.
  task automatic run_op(
    input string       name,
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] exp
  );
    int   cyc;
    logic ok_wait;
    iValid = 1'b1;
    iALUOP = op;
    iA     = a;
    iB     = b;
    iReady = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iValid  = 1'b0;
    iALUOP  = 4'($urandom);
    iA      = $urandom;
    iB      = $urandom;
    cyc     = 1;
    ok_wait = 1'b1;
    while (!oValid && cyc < 40) begin
      if (oReady !== 1'b0 || oBusy !== 1'b1)
        ok_wait = 1'b0;
      @(negedge iClk);
      cyc++;
    end
    chk({name, " latency"}, 32'(cyc),
        32'(model_lat(op, b)));
    chk({name, " result"}, oResult, exp);
    chk({name, " zero"}, 32'(oZero),
        32'(exp == 32'd0));
    chk({name, " ready low"}, 32'(ok_wait), 32'd1);
    @(negedge iClk);
    chk({name, " idle"},
        32'({oValid, oBusy, oReady}), 32'b001);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        seen;

    tbl = '{
      '{4'h0, 32'hFFFFFFFF, 32'h1, 32'h0},
      '{4'h1, 32'd5, 32'd7, 32'hFFFFFFFE},
      '{4'h8, 32'hFFFFFFFF, 32'd1, 32'd1},
      '{4'h9, 32'hFFFFFFFF, 32'd1, 32'd0},
      '{4'h2, 32'hA5A5A5A5, 32'hFFFFFFFF,
        32'h5A5A5A5A},
      '{4'h7, 32'h80000000, 32'd4, 32'hF8000000},
      '{4'h4, 32'hF0F0, 32'h0FF0, 32'hF0},
      '{4'h3, 32'h0F00, 32'h00F0, 32'h0FF0},
      '{4'hC, 32'd2, 32'd3, 32'd5},
      '{4'hF, 32'd7, 32'hFFFFFFFF, 32'd6},
      '{4'h5, 32'd1, 32'h21, 32'd2},
      '{4'h5, 32'h12345678, 32'd0, 32'h12345678},
      '{4'h6, 32'h80000000, 32'd31, 32'd1},
      '{4'h7, 32'h7FFFFFFF, 32'd31, 32'd0},
      '{4'h8, 32'd1, 32'hFFFFFFFF, 32'd0},
      '{4'h9, 32'd1, 32'hFFFFFFFF, 32'd1},
      '{4'h5, 32'd1, 32'd31, 32'h80000000},
      '{4'h7, 32'h80000000, 32'd31, 32'hFFFFFFFF}
    };

    iRst_n = 1'b0;
    iValid = 1'b0;
    iReady = 1'b1;
    iALUOP = 4'h0;
    iA     = 32'h0;
    iB     = 32'h0;
    repeat (2) @(negedge iClk);
    chk("reset valid", 32'(oValid), 32'd0);
    chk("reset result", oResult, 32'd0);
    chk("reset zero", 32'(oZero), 32'd1);
    chk("reset busy", 32'(oBusy), 32'd0);
    chk("reset ready", 32'(oReady), 32'd1);
    iRst_n = 1'b1;
    @(negedge iClk);

    for (int i = 0; i < 18; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op,
             tbl[i].a, tbl[i].b, tbl[i].res);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom);
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 0) a = 32'h80000000 | a;
      if (i % 5 == 0) b = a;
      run_op($sformatf("rnd%0d", i), op, a, b,
             model(op, a, b));
    end

    // Result held under backpressure, then drained and
    // refilled on the same edge.
    iValid = 1'b1;
    iALUOP = 4'h0;
    iA     = 32'd10;
    iB     = 32'd20;
    iReady = 1'b0;
    @(posedge iClk);
    @(negedge iClk);
    iValid = 1'b0;
    iA     = 32'd99;
    for (int k = 0; k < 3; k++) begin
      chk("bp valid", 32'(oValid), 32'd1);
      chk("bp result", oResult, 32'd30);
      chk("bp ready", 32'(oReady), 32'd0);
      @(negedge iClk);
    end
    iValid = 1'b1;
    iALUOP = 4'h4;
    iA     = 32'hF0F0;
    iB     = 32'h0FF0;
    iReady = 1'b1;
    #1;
    chk("bp drain ready", 32'(oReady), 32'd1);
    @(posedge iClk);
    @(negedge iClk);
    iValid = 1'b0;
    chk("bp next valid", 32'(oValid), 32'd1);
    chk("bp next result", oResult, 32'h000000F0);
    @(negedge iClk);
    chk("bp idle", 32'(oValid), 32'd0);

    // Reset mid-shift abandons the operation.
    iValid = 1'b1;
    iALUOP = 4'h5;
    iA     = 32'd1;
    iB     = 32'd31;
    @(posedge iClk);
    @(negedge iClk);
    iValid = 1'b0;
    repeat (9) @(negedge iClk);
    iRst_n = 1'b0;
    #1;
    chk("rst valid", 32'(oValid), 32'd0);
    chk("rst busy", 32'(oBusy), 32'd0);
    chk("rst result", oResult, 32'd0);
    chk("rst zero", 32'(oZero), 32'd1);
    @(negedge iClk);
    iRst_n = 1'b1;
    seen = 1'b0;
    repeat (35) begin
      @(negedge iClk);
      if (oValid) seen = 1'b1;
    end
    chk("rst no pulse", 32'(seen), 32'd0);
    run_op("post-rst add", 4'h0, 32'd2, 32'd3, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
